// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple adder,
// processing one nibble per clock with a start/busy/done handshake.

module full_adder_1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module full_adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        full_adder_1 u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[4];

endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    nib_cnt;
    logic [CW+1:0]    base;

    logic [3:0]       fa_a;
    logic [3:0]       fa_b;
    logic [3:0]       fa_s;
    logic             fa_co;
    logic             ovf_nxt;

    // Bit offset of the nibble currently being processed
    assign base = {nib_cnt, 2'b00};
    assign fa_a = a_q[base +: 4];
    assign fa_b = b_q[base +: 4];

    full_adder_4 u_fa4 (
        .a  (fa_a),
        .b  (fa_b),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // fa_s[3] is the final sum MSB on the last nibble pass
    assign ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (fa_s[3] != a_q[WIDTH-1]);

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            nib_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        nib_cnt <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        ovf     <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: 4] <= fa_s;
                    carry_q        <= fa_co;
                    nib_cnt        <= nib_cnt + CW'(1);
                    if (nib_cnt == LAST) begin
                        cout  <= fa_co;
                        ovf   <= ovf_nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition by reusing a single 4-bit ripple-carry adder datapath (full_adder_4 instance) over WIDTH/4 clock cycles, one nibble per cycle.
- Holds the carry between nibbles and assembles the wide result.
- Used where a full-width combinational adder costs too much area; provides a start/busy/done handshake to the requesting logic.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble passes (derived localparam, not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse/level; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in to nibble 0; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; result valid.
- sum  output  WIDTH  registered result; held until next accepted start.
- cout  output  1  carry out of the MSB nibble; registered.
- ovf  output  1  signed (two's complement) overflow flag; registered.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal operand regs, carry reg and nibble counter cleared.
- An operation in flight during reset is discarded; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at a rising edge, then at that edge:
  - latch a, b and cin (into the carry reg);
  - clear nib_cnt;
  - clear sum, cout and ovf;
  - go to RUN.
- With start=0 in IDLE, the state holds.
- RUN: each edge feeds nibble nib_cnt of latched A/B plus the carry reg to the 4-bit adder.
  - Write the 4-bit sum into sum[4*nib_cnt+3 : 4*nib_cnt].
  - Load the adder carry-out into the carry reg.
  - Increment nib_cnt.
  - On the edge processing nibble NIB-1, go to DONE and register cout = that edge's adder carry-out.
  - Register ovf = (A[WIDTH-1]==B[WIDTH-1]) && (final sum[WIDTH-1] != A[WIDTH-1]).
- DONE: done=1 for exactly this one cycle; next edge goes unconditionally to IDLE.
- Latency: with the start-accept edge as E0, nibbles are processed on E1..E_NIB. done is high in the cycle after E_NIB and low after E_(NIB+1).
  - WIDTH=16: done is high between E4 and E5.
  - Minimum start-to-start spacing is NIB+2 edges.
- start while busy=1 is ignored. Operand/cin changes after acceptance have no effect.
- start held continuously high: a new operation is accepted on the first edge in IDLE after DONE, i.e. back-to-back at NIB+2 edges.
- Arithmetic is unsigned modulo 2^WIDTH; {cout,sum} = A + B + cin exactly.
- Carry propagates across all nibble boundaries, including full ripple (e.g. all-ones + 1).
- ovf does not include cin's contribution to the sign separately; it is defined purely by the sign-bit rule above.
- sum, cout and ovf are stable from DONE until the next accepted start. Partial sum bits may be observed during RUN and are not valid until done.

Test Plan (WIDTH=16):
- Reset then idle: assert reset mid-cycle (async) -> busy=0, done=0, sum=16'h0000, cout=0, ovf=0 immediately; no activity with start=0 for 10 cycles.
- a=16'h1234, b=16'h4321, cin=0, start pulse at E0 -> busy high E0..E5, done high only between E4 and E5, sum=16'h5555, cout=0, ovf=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0 (carry through all 4 nibbles). Then a=16'h0000, b=16'h0000, cin=1 -> sum=16'h0001, cout=0.
- a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1. Then a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
- Start 16'h0F0F+16'h00F1. Pulse start again with a=16'hAAAA at E2, and change a/b during RUN -> second start ignored, result sum=16'h1000, exactly one done pulse.
- Assert reset at E2 of an operation -> all outputs 0, state IDLE, no done pulse. Hold start high continuously with fixed operands -> done pulses every 6 edges, identical results each time.
